// File: rtl/wb_dram_model_pkg.sv
// wb_dram_model_pkg: shared FSM state type and default bus geometry for the DRAM stand-in.
package wb_dram_model_pkg;
    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_BUSY, ST_RESP} state_t;
    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_ADDR_WIDTH = 25;
    localparam int DEF_SEL_WIDTH  = DEF_DATA_WIDTH / 8;
endpackage

// File: rtl/wb_dram_model_mem.sv
// wb_dram_model_mem: single-port RAM with per-byte write enable and a registered, hold-until-read output.
// Ports: clk, rst_n (clears only the read register), we/re strobes, addr, sel byte enables, din, dout.
module wb_dram_model_mem #(
    parameter int DATA_WIDTH = 256,
    parameter int DEPTH      = 1024,
    parameter int AW         = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic                    re,
    input  logic [AW-1:0]           addr,
    input  logic [DATA_WIDTH/8-1:0] sel,
    input  logic [DATA_WIDTH-1:0]   din,
    output logic [DATA_WIDTH-1:0]   dout
);
    logic [DATA_WIDTH-1:0] ram [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++)
            if (we && sel[i]) ram[addr][8*i +: 8] <= din[8*i +: 8];
    end

    // dout only moves on a read strobe so it doubles as the held bus read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dout <= '0;
        else if (re) dout <= ram[addr];
    end
endmodule

// File: rtl/wb_dram_model.sv
// wb_dram_model: Wishbone classic responder emulating a LiteDRAM user port with fixed latency and init sequence.
// Ports: clk, rst_n (async, active-low), inject_error, init_done/init_error, Wishbone cyc/stb/we/adr/sel/dat_w/dat_r/ack/err.
module wb_dram_model
    import wb_dram_model_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH       = 1024,
    parameter int LATENCY     = 4,
    parameter int INIT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inject_error,
    output logic                    init_done,
    output logic                    init_error,
    input  logic                    wb_cyc,
    input  logic                    wb_stb,
    input  logic                    wb_we,
    input  logic [ADDR_WIDTH-1:0]   wb_adr,
    input  logic [DATA_WIDTH/8-1:0] wb_sel,
    input  logic [DATA_WIDTH-1:0]   wb_dat_w,
    output logic [DATA_WIDTH-1:0]   wb_dat_r,
    output logic                    wb_ack,
    output logic                    wb_err
);
    localparam int SW  = DATA_WIDTH / 8;
    localparam int MAW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int LCW = LATENCY > 2 ? $clog2(LATENCY) : 1;
    localparam int ICW = INIT_CYCLES > 1 ? $clog2(INIT_CYCLES) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state;
    logic [ICW-1:0]          icnt;
    logic [LCW-1:0]          lcnt;
    logic [ADDR_WIDTH-1:0]   adr_q;
    logic                    we_q;
    logic [SW-1:0]           sel_q;
    logic [DATA_WIDTH-1:0]   dat_q;

    logic                    accept;
    logic                    respond;
    logic                    ok;
    logic                    cur_we;
    logic [ADDR_WIDTH-1:0]   cur_adr;
    logic [SW-1:0]           cur_sel;
    logic [DATA_WIDTH-1:0]   cur_dat;

    // In IDLE the live bus is used so LATENCY=1 can respond at the accepting edge
    assign accept  = state == ST_IDLE && wb_cyc && wb_stb;
    assign cur_we  = state == ST_IDLE ? wb_we    : we_q;
    assign cur_adr = state == ST_IDLE ? wb_adr   : adr_q;
    assign cur_sel = state == ST_IDLE ? wb_sel   : sel_q;
    assign cur_dat = state == ST_IDLE ? wb_dat_w : dat_q;
    // The latency counter is preloaded two short so the response registers land in the LATENCY-th cycle
    assign respond = LATENCY == 1 ? accept : (state == ST_BUSY && wb_cyc && lcnt == '0);
    assign ok      = !init_error && ({1'b0, cur_adr} < DEPTH_W);

    wb_dram_model_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .AW        (MAW)
    ) u_mem (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (respond && ok && cur_we),
        .re   (respond && ok && !cur_we),
        .addr (cur_adr[MAW-1:0]),
        .sel  (cur_sel),
        .din  (cur_dat),
        .dout (wb_dat_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            icnt       <= '0;
            lcnt       <= '0;
            init_done  <= 1'b0;
            init_error <= 1'b0;
            wb_ack     <= 1'b0;
            wb_err     <= 1'b0;
            adr_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            dat_q      <= '0;
        end else begin
            wb_ack <= respond && ok;
            wb_err <= respond && !ok;
            case (state)
                ST_INIT: begin
                    icnt <= icnt + 1'b1;
                    if (icnt == ICW'(INIT_CYCLES - 1)) begin
                        init_done  <= 1'b1;
                        init_error <= inject_error;
                        state      <= ST_IDLE;
                    end
                end
                ST_IDLE: if (accept) begin
                    adr_q <= wb_adr;
                    we_q  <= wb_we;
                    sel_q <= wb_sel;
                    dat_q <= wb_dat_w;
                    lcnt  <= LCW'(LATENCY > 1 ? LATENCY - 2 : 0);
                    state <= respond ? ST_RESP : ST_BUSY;
                end
                ST_BUSY: begin
                    lcnt  <= lcnt - 1'b1;
                    state <= !wb_cyc ? ST_IDLE : respond ? ST_RESP : ST_BUSY;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_dram_model.sv
// tb_wb_dram_model: randomized and directed checks of wb_dram_model against a byte-level reference model.
module tb_wb_dram_model;
    localparam int DW = 256;
    localparam int AW = 25;
    localparam int SW = 32;
    localparam int DEPTH = 1024;
    localparam int LAT = 4;
    localparam int INIT = 16;

    logic clk = 0;
    logic rst_n = 0;
    logic inject_error = 0;
    logic init_done, init_error;
    logic wb_cyc = 0, wb_stb = 0, wb_we = 0;
    logic [AW-1:0] wb_adr = '0;
    logic [SW-1:0] wb_sel = '0;
    logic [DW-1:0] wb_dat_w = '0;
    logic [DW-1:0] wb_dat_r;
    logic wb_ack, wb_err;

    wb_dram_model #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .LATENCY(LAT), .INIT_CYCLES(INIT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .inject_error(inject_error),
        .init_done(init_done), .init_error(init_error),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
        .wb_sel(wb_sel), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
        .wb_ack(wb_ack), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        bit            err;
        bit            rd;
        logic [DW-1:0] data;
        logic [DW-1:0] mask;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] m_dat [DEPTH];
    logic [DW-1:0] m_val [DEPTH];
    logic [DW-1:0] last_rd = '0;
    logic [DW-1:0] last_mask = '1;
    bit            inj_m = 0;
    int            cyc_n = 0;
    int            since = 0;
    int            n_chk = 0;
    int            n_pass = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;
    always @(posedge clk or negedge rst_n) if (!rst_n) since <= 0; else since <= since + 1;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin : cmp
        bit ea, ee;
        ea = 0;
        ee = 0;
        if (q.size() > 0 && q[0].cyc == cyc_n) begin
            ea = !q[0].err;
            ee = q[0].err;
            if (ea && q[0].rd) begin
                last_rd   = q[0].data;
                last_mask = q[0].mask;
            end
            void'(q.pop_front());
        end
        check("ack", 256'(wb_ack), 256'(ea));
        check("err", 256'(wb_err), 256'(ee));
        check("init_done", 256'(init_done), 256'(since >= INIT));
        check("init_error", 256'(init_error), 256'(since >= INIT && inj_m));
        check("dat_r", wb_dat_r & last_mask, last_rd & last_mask);
    end

    function automatic logic [DW-1:0] rand_w();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic xfer(input bit we, input int adr, input logic [SW-1:0] sel, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output int lat, output bit ak);
        exp_t e;
        int t0;
        logic [DW-1:0] bm;
        @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = AW'(adr); wb_sel = sel; wb_dat_w = d;
        t0 = cyc_n;
        for (int i = 0; i < SW; i++) bm[8*i +: 8] = {8{sel[i]}};
        e.cyc = t0 + LAT;
        e.err = inj_m || adr >= DEPTH;
        e.rd = !we;
        e.data = '0;
        e.mask = '0;
        if (!e.err) begin
            if (we) begin
                m_dat[adr] = (m_dat[adr] & ~bm) | (d & bm);
                m_val[adr] = m_val[adr] | bm;
            end else begin
                e.data = m_dat[adr];
                e.mask = m_val[adr];
            end
        end
        q.push_back(e);
        lat = -1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (wb_ack || wb_err) lat = cyc_n - t0;
        end
        rd = wb_dat_r;
        ak = wb_ack;
        check("resp_seen", 256'(lat >= 0), 256'(1));
        wb_cyc = 0; wb_stb = 0;
    endtask

    task automatic assert_rst(input bit inj);
        rst_n = 0;
        inject_error = inj;
        inj_m = inj;
        wb_cyc = 0; wb_stb = 0;
        q.delete();
        last_rd = '0;
        last_mask = '1;
        for (int i = 0; i < DEPTH; i++) m_val[i] = '0;
    endtask

    task automatic release_rst(input bit inj);
        int t;
        repeat (3) @(negedge clk);
        rst_n = 1;
        t = -1;
        for (int i = 0; i < 40 && t < 0; i++) begin
            @(negedge clk);
            if (init_done) t = since;
        end
        check("init_rise", 256'(t), 256'(INIT));
        check("init_error_lvl", 256'(init_error), 256'(inj));
    endtask

    task automatic rand_phase(input int n);
        logic [DW-1:0] rd;
        int lat;
        bit ak;
        for (int k = 0; k < n; k++) begin
            int adr;
            logic [SW-1:0] sel;
            adr = ($urandom % 4 == 0) ? int'($urandom_range(DEPTH, 33554431)) : int'($urandom_range(8, 15));
            sel = ($urandom % 4 == 0) ? '1 : SW'($urandom);
            xfer(bit'($urandom % 2), adr, sel, rand_w(), rd, lat, ak);
            check("rand_lat", 256'(lat), 256'(LAT));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] rd;
        logic [DW-1:0] p5, p976, p3;
        int lat;
        bit ak;
        p5   = {2{128'hAABBCCDDEEFF00112233445566778899}};
        p976 = {8{32'h13572468}};
        p3   = {32{8'h11}};
        assert_rst(0);
        release_rst(0);

        xfer(1, 5, '1, p5, rd, lat, ak);
        check("wr5_lat", 256'(lat), 256'(4));
        check("wr5_ack", 256'(ak), 256'(1));
        xfer(0, 5, '0, '0, rd, lat, ak);
        check("rd5_lat", 256'(lat), 256'(4));
        check("rd5_data", rd, {2{128'hAABBCCDDEEFF00112233445566778899}});

        xfer(1, 7, '1, '1, rd, lat, ak);
        xfer(1, 7, 32'h0000FFFF, '0, rd, lat, ak);
        xfer(0, 7, '0, '0, rd, lat, ak);
        check("rd7_partial", rd, {{128{1'b1}}, 128'h0});

        xfer(1, 976, '1, p976, rd, lat, ak);
        xfer(1, 2000, '1, rand_w(), rd, lat, ak);
        check("wr2000_ack", 256'(ak), 256'(0));
        check("wr2000_lat", 256'(lat), 256'(4));
        xfer(0, 1024, '0, '0, rd, lat, ak);
        check("rd1024_ack", 256'(ak), 256'(0));
        check("rd1024_hold", rd, {{128{1'b1}}, 128'h0});
        xfer(0, 976, '0, '0, rd, lat, ak);
        check("rd976_data", rd, {8{32'h13572468}});

        xfer(1, 3, '1, p3, rd, lat, ak);
        @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 25'd3; wb_sel = '1; wb_dat_w = {32{8'h5A}};
        repeat (2) @(negedge clk);
        wb_cyc = 0; wb_stb = 0;
        repeat (6) @(negedge clk);
        xfer(0, 3, '0, '0, rd, lat, ak);
        check("rd3_after_abort", rd, {32{8'h11}});

        rand_phase(200);

        xfer(0, 5, '0, '0, rd, lat, ak);
        @(negedge clk);
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 25'd9; wb_sel = '1; wb_dat_w = rand_w();
        repeat (2) @(negedge clk);
        #2;
        assert_rst(1);
        #1;
        check("rst_ack", 256'(wb_ack), 256'(0));
        check("rst_err", 256'(wb_err), 256'(0));
        check("rst_done", 256'(init_done), 256'(0));
        check("rst_dat_r", wb_dat_r, 256'(0));
        release_rst(1);

        xfer(1, 5, '1, p5, rd, lat, ak);
        check("inj_wr_ack", 256'(ak), 256'(0));
        check("inj_wr_lat", 256'(lat), 256'(4));
        xfer(0, 5, '0, '0, rd, lat, ak);
        check("inj_rd_ack", 256'(ak), 256'(0));
        rand_phase(20);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
